// File: rtl/compa16_axil_slave.sv
// AXI4-Lite register slave for the 16-bit magnitude comparator peripheral.
// Holds operands A/B and CTRL, and exposes a registered compare result.
module compa16_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int CMP_WIDTH          = 16
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              cmp_lt,
    output logic                              cmp_eq,
    output logic                              cmp_gt
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    w_state_t w_state;
    r_state_t r_state;

    logic [DW-1:0] reg_a;
    logic [DW-1:0] reg_b;
    logic [DW-1:0] ctrl;

    logic          awready_q;
    logic          wready_q;
    logic          bvalid_q;
    logic          arready_q;
    logic          rvalid_q;
    logic [DW-1:0] rdata_q;

    logic [1:0]    aw_idx_q;
    logic [DW-1:0] wdata_q;
    logic [SW-1:0] wstrb_q;

    logic          lt_q;
    logic          eq_q;
    logic          gt_q;
    logic          valid_q;

    logic aw_fire;
    logic w_fire;
    logic ar_fire;

    assign aw_fire = S_AXI_AWVALID && awready_q;
    assign w_fire  = S_AXI_WVALID && wready_q;
    assign ar_fire = S_AXI_ARVALID && arready_q;

    logic          commit;
    logic [1:0]    c_idx;
    logic [DW-1:0] c_data;
    logic [SW-1:0] c_strb;

    // Merge the live channel with whichever half was latched earlier
    always_comb begin
        commit = 1'b0;
        c_idx  = S_AXI_AWADDR[3:2];
        c_data = S_AXI_WDATA;
        c_strb = S_AXI_WSTRB;
        unique case (w_state)
            W_IDLE: commit = aw_fire && w_fire;
            W_HAVE_ADDR: begin
                commit = w_fire;
                c_idx  = aw_idx_q;
            end
            W_HAVE_DATA: begin
                commit = aw_fire;
                c_data = wdata_q;
                c_strb = wstrb_q;
            end
            W_RESP: ;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (commit) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        w_state   <= W_RESP;
                    end else if (aw_fire) begin
                        aw_idx_q  <= S_AXI_AWADDR[3:2];
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state   <= W_HAVE_ADDR;
                    end else if (w_fire) begin
                        wdata_q   <= S_AXI_WDATA;
                        wstrb_q   <= S_AXI_WSTRB;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b0;
                        w_state   <= W_HAVE_DATA;
                    end else begin
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                W_HAVE_ADDR: begin
                    if (commit) begin
                        wready_q <= 1'b0;
                        bvalid_q <= 1'b1;
                        w_state  <= W_RESP;
                    end
                end
                W_HAVE_DATA: begin
                    if (commit) begin
                        awready_q <= 1'b0;
                        bvalid_q  <= 1'b1;
                        w_state   <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            reg_a <= '0;
            reg_b <= '0;
            ctrl  <= '0;
        end else if (commit) begin
            for (int i = 0; i < SW; i++) begin
                if (c_strb[i]) begin
                    unique case (c_idx)
                        2'd0: reg_a[8*i +: 8] <= c_data[8*i +: 8];
                        2'd1: reg_b[8*i +: 8] <= c_data[8*i +: 8];
                        2'd2: ctrl[8*i +: 8]  <= c_data[8*i +: 8];
                        default: ;
                    endcase
                end
            end
        end
    end

    logic [DW-1:0] status;
    logic [DW-1:0] rd_mux;

    assign status = {{(DW-4){1'b0}}, valid_q, gt_q, eq_q, lt_q};

    always_comb begin
        rd_mux = status;
        unique case (S_AXI_ARADDR[3:2])
            2'd0: rd_mux = reg_a;
            2'd1: rd_mux = reg_b;
            2'd2: rd_mux = ctrl;
            2'd3: rd_mux = status;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        rdata_q   <= rd_mux;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        r_state   <= R_DATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state   <= R_IDLE;
                    end
                end
            endcase
        end
    end

    logic [CMP_WIDTH-1:0] op_a;
    logic [CMP_WIDTH-1:0] op_b;
    logic                 a_lt_b;
    logic                 a_eq_b;

    assign op_a   = reg_a[CMP_WIDTH-1:0];
    assign op_b   = reg_b[CMP_WIDTH-1:0];
    assign a_eq_b = (op_a == op_b);

    // CTRL[0] selects two's-complement ordering
    always_comb begin
        if (ctrl[0]) a_lt_b = ($signed(op_a) < $signed(op_b));
        else         a_lt_b = (op_a < op_b);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            lt_q    <= a_lt_b;
            eq_q    <= a_eq_b;
            gt_q    <= !a_lt_b && !a_eq_b;
            valid_q <= 1'b1;
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR, S_AXI_ARADDR};

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign cmp_lt        = lt_q;
    assign cmp_eq        = eq_q;
    assign cmp_gt        = gt_q;

endmodule

// File: tb/tb_compa16_axil_slave.sv
// Scoreboard bench for compa16_axil_slave: directed writes/reads,
// expected responses queued at issue and checked by a monitor.
module tb_compa16_axil_slave;

    logic        clk;
    logic        arst_n;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        cmp_lt;
    logic        cmp_eq;
    logic        cmp_gt;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] rq[$];
    logic [1:0]  bq[$];

    compa16_axil_slave dut (
        .ACLK          (clk),
        .ARESETN       (arst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .cmp_lt        (cmp_lt),
        .cmp_eq        (cmp_eq),
        .cmp_gt        (cmp_gt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    // Monitor: pops the scoreboard whenever a response handshake is seen
    always @(negedge clk) begin
        if (rvalid && rready) begin
            if (rq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rdata_unexpected: got %h expected none", rdata);
            end else begin
                check("rdata", rdata, rq.pop_front());
                check("rresp", {30'd0, rresp}, 32'd0);
            end
        end
        if (bvalid && bready) begin
            if (bq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL bresp_unexpected: got %h expected none", bresp);
            end else begin
                check("bresp", {30'd0, bresp}, {30'd0, bq.pop_front()});
            end
        end
    end

    // mode: 0 = AW+W together, 1 = W two cycles ahead, 2 = AW two cycles ahead
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int mode,
                             input int hold);
        bit aw_done;
        bit w_done;
        bit aw_hs;
        bit w_hs;
        bit bdone;
        int n;
        bq.push_back(2'b00);
        @(posedge clk); #1;
        awaddr = a;
        wdata  = d;
        wstrb  = s;
        bready = (hold == 0);
        if (mode != 1) awvalid = 1'b1;
        if (mode != 2) wvalid = 1'b1;
        aw_done = 0;
        w_done  = 0;
        n = 0;
        while (!(aw_done && w_done) && n < 50) begin
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin wvalid = 1'b0;  w_done = 1;  end
            n++;
            if (n == 2 && mode == 1) awvalid = 1'b1;
            if (n == 2 && mode == 2) wvalid = 1'b1;
        end
        if (!(aw_done && w_done)) timeout("aw_w_handshake");
        awvalid = 1'b0;
        wvalid  = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("b_stall_bvalid_awready_wready",
                  {29'd0, bvalid, awready, wready}, 32'h4);
            @(posedge clk); #1;
        end
        bready = 1'b1;
        bdone = 0;
        n = 0;
        while (!bdone && n < 50) begin
            @(negedge clk);
            bdone = bvalid && bready;
            @(posedge clk); #1;
            n++;
        end
        if (!bdone) timeout("b_handshake");
    endtask

    task automatic axi_read(input logic [3:0] a, input logic [31:0] exp,
                            input int stall);
        bit done;
        int n;
        rq.push_back(exp);
        @(posedge clk); #1;
        araddr  = a;
        arvalid = 1'b1;
        rready  = (stall == 0);
        done = 0;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            done = arvalid && arready;
            @(posedge clk); #1;
            n++;
        end
        if (!done) timeout("ar_handshake");
        arvalid = 1'b0;
        if (stall > 0) begin
            // Offer a competing AR during the stall; it must not be taken
            araddr  = 4'h0;
            arvalid = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check("r_stall_rdata", rdata, exp);
                check("r_stall_rvalid_arready", {30'd0, rvalid, arready}, 32'h2);
                @(posedge clk); #1;
            end
            arvalid = 1'b0;
            rready  = 1'b1;
        end
        done = 0;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            done = rvalid && rready;
            @(posedge clk); #1;
            n++;
        end
        if (!done) timeout("r_handshake");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n  = 1'b0;
        awaddr  = '0;
        awprot  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        araddr  = '0;
        arprot  = '0;
        arvalid = 1'b0;
        rready  = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_readys_valids",
              {27'd0, awready, wready, bvalid, arready, rvalid}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_cmp", {29'd0, cmp_lt, cmp_eq, cmp_gt}, 32'h0);
        @(posedge clk); #1;
        arst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic register access and first status
        axi_write(4'h0, 32'h1, 4'hF, 0, 0);
        axi_write(4'h4, 32'h2, 4'hF, 0, 0);
        axi_write(4'h8, 32'h3, 4'hF, 0, 0);
        axi_read(4'h0, 32'h1, 0);
        axi_read(4'h4, 32'h2, 0);
        axi_read(4'h8, 32'h3, 0);
        axi_read(4'hC, 32'h9, 0);

        // STATUS is read-only
        axi_write(4'hC, 32'h4, 4'hF, 0, 0);
        axi_read(4'hC, 32'h9, 0);

        // Unsigned then signed compare
        axi_write(4'h0, 32'hFFFF, 4'hF, 0, 0);
        axi_write(4'h4, 32'h0001, 4'hF, 0, 0);
        axi_write(4'h8, 32'h0, 4'hF, 0, 0);
        axi_read(4'hC, 32'hC, 0);
        check("pins_gt", {29'd0, cmp_lt, cmp_eq, cmp_gt}, 32'h1);
        axi_write(4'h8, 32'h1, 4'hF, 0, 0);
        axi_read(4'hC, 32'h9, 0);
        check("pins_lt", {29'd0, cmp_lt, cmp_eq, cmp_gt}, 32'h4);
        axi_write(4'h4, 32'hFFFF, 4'hF, 0, 0);
        axi_read(4'hC, 32'hA, 0);
        check("pins_eq", {29'd0, cmp_lt, cmp_eq, cmp_gt}, 32'h2);

        // Split address/data ordering with B stall
        axi_write(4'h0, 32'h12345678, 4'hF, 1, 5);
        axi_write(4'h4, 32'h9ABCDEF0, 4'hF, 2, 5);
        axi_read(4'h0, 32'h12345678, 0);
        axi_read(4'h4, 32'h9ABCDEF0, 0);

        // Byte strobes
        axi_write(4'h0, 32'hAABBCCDD, 4'hF, 0, 0);
        axi_write(4'h0, 32'h11223344, 4'b0101, 0, 0);
        axi_read(4'h0, 32'hAA22CC44, 0);

        // R stall
        axi_read(4'h4, 32'h9ABCDEF0, 4);

        // Reset in the middle of a write response
        @(posedge clk); #1;
        bready  = 1'b0;
        awaddr  = 4'h8;
        wdata   = 32'h55;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        @(negedge clk);
        check("mid_rst_accept", {30'd0, awready, wready}, 32'h3);
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("mid_rst_bvalid_pre", {31'd0, bvalid}, 32'h1);
        #2;
        arst_n = 1'b0;
        #1;
        check("mid_rst_async_drop",
              {27'd0, awready, wready, bvalid, arready, rvalid}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        arst_n = 1'b1;
        bready = 1'b1;
        repeat (2) @(posedge clk);
        axi_read(4'h0, 32'h0, 0);
        axi_read(4'h4, 32'h0, 0);
        axi_read(4'h8, 32'h0, 0);
        axi_read(4'hC, 32'hA, 0);

        repeat (3) @(posedge clk);
        check("rq_drained", rq.size(), 32'd0);
        check("bq_drained", bq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
